// File: rtl/sfr_access_arbiter_pkg.sv
// Shared types for the SFR access arbiter: operation codes, FSM states, port count.
package sfr_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        SFR_READ  = 2'b00,
        SFR_WRITE = 2'b01,
        SFR_SET   = 2'b10,
        SFR_CLEAR = 2'b11
    } sfr_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        DONE   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sfr_access_arbiter_if.sv
// Requester handshakes plus the shared SFR bank lines.
interface sfr_access_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic [1:0]            m0_op;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_ready;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m1_req;
    logic [1:0]            m1_op;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_ready;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic [ADDR_WIDTH-1:0] sfr_addr;
    logic                  sfr_wr_en;
    logic [DATA_WIDTH-1:0] sfr_wdata;
    logic [DATA_WIDTH-1:0] sfr_rdata;

    modport slave (
        input  m0_req, m0_op, m0_addr, m0_wdata,
        output m0_ready, m0_rdata,
        input  m1_req, m1_op, m1_addr, m1_wdata,
        output m1_ready, m1_rdata,
        output sfr_addr, sfr_wr_en, sfr_wdata,
        input  sfr_rdata
    );

    modport master (
        output m0_req, m0_op, m0_addr, m0_wdata,
        input  m0_ready, m0_rdata,
        output m1_req, m1_op, m1_addr, m1_wdata,
        input  m1_ready, m1_rdata,
        input  sfr_addr, sfr_wr_en, sfr_wdata,
        output sfr_rdata
    );
endinterface

// File: rtl/sfr_access_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the port that wins a tie.
module sfr_rr_arb2 (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_idx = ptr_q;
        if (!req[ptr_q]) gnt_idx = ~ptr_q;
        gnt     = (req == 2'b00) ? 2'b00 : (2'b01 << gnt_idx);
        ptr_d   = advance ? ~gnt_idx : ptr_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/sfr_access_arbiter.sv
// Serialises two requesters onto the SFR bank; SET/CLEAR run as read-modify-write.
module sfr_access_arbiter
    import sfr_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = {ADDR_WIDTH{1'b1}}
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    sfr_access_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 owner
);
    arb_state_e                  state_q, state_d;
    sfr_op_e                     op_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q, rdata_q;
    logic                        owner_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] mrdata_q;

    logic [1:0] req_vec, gnt;
    logic       gnt_idx, grant, done;
    sfr_op_e    win_op;

    assign req_vec = {bus.m1_req, bus.m0_req};
    assign grant   = (state_q == IDLE) && (|req_vec);
    assign win_op  = sfr_op_e'(gnt_idx ? bus.m1_op : bus.m0_op);

    // Pointer moves at grant time; it is only consulted in IDLE, so this
    // is indistinguishable from moving it at completion.
    sfr_rr_arb2 u_arb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req_vec),
        .advance (grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = (win_op inside {SFR_SET, SFR_CLEAR}) ? RMW_RD : ACCESS;
            ACCESS:  state_d = DONE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            op_q     <= SFR_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            owner_q  <= 1'b0;
            mrdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                op_q    <= win_op;
                addr_q  <= gnt_idx ? bus.m1_addr  : bus.m0_addr;
                wdata_q <= gnt_idx ? bus.m1_wdata : bus.m0_wdata;
                owner_q <= gnt[1];
            end
            if (state_q == ACCESS || state_q == RMW_RD) rdata_q <= bus.sfr_rdata;
            if (state_q == DONE) mrdata_q[owner_q] <= rdata_q;
        end
    end

    // Bus lines derive only from state and latched fields; reset masks any write that cycle.
    always_comb begin
        bus.sfr_addr  = IDLE_ADDR;
        bus.sfr_wr_en = 1'b0;
        bus.sfr_wdata = '0;
        if (!sys_rst) begin
            case (state_q)
                ACCESS: begin
                    bus.sfr_addr  = addr_q;
                    bus.sfr_wr_en = (op_q == SFR_WRITE);
                    bus.sfr_wdata = wdata_q;
                end
                RMW_RD: bus.sfr_addr = addr_q;
                RMW_WR: begin
                    bus.sfr_addr  = addr_q;
                    bus.sfr_wr_en = 1'b1;
                    bus.sfr_wdata = (op_q == SFR_SET) ? (rdata_q | wdata_q) : (rdata_q & ~wdata_q);
                end
                default: ;
            endcase
        end
    end

    assign done         = (state_q == DONE) && !sys_rst;
    assign bus.m0_ready = done && !owner_q;
    assign bus.m1_ready = done &&  owner_q;
    assign bus.m0_rdata = bus.m0_ready ? rdata_q : mrdata_q[0];
    assign bus.m1_rdata = bus.m1_ready ? rdata_q : mrdata_q[1];
    assign busy         = (state_q != IDLE);
    assign owner        = owner_q;
endmodule

// File: tb/tb_sfr_access_arbiter.sv
// Directed bench for sfr_access_arbiter with a small SFR bank model.
module tb_sfr_access_arbiter;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic busy, owner;

    int checks = 0;
    int failures = 0;

    sfr_access_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sfr_access_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 sys_clk = ~sys_clk;

    // Bank model: 256 words, anything above reads as zero.
    logic [31:0] mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    int          rdy0_cnt = 0, rdy1_cnt = 0;

    assign bus.sfr_rdata = (bus.sfr_addr < 32'd256) ? mem[bus.sfr_addr[7:0]] : 32'h0;

    always @(posedge sys_clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.sfr_wr_en) begin
            if (bus.sfr_addr < 32'd256) mem[bus.sfr_addr[7:0]] <= bus.sfr_wdata;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.sfr_addr;
            last_wr_data <= bus.sfr_wdata;
        end
    end

    always @(negedge sys_clk) begin
        if (bus.m0_ready) rdy0_cnt <= rdy0_cnt + 1;
        if (bus.m1_ready) rdy1_cnt <= rdy1_cnt + 1;
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(posedge sys_clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge sys_clk); #1;
        poke_en = 1'b0;
    endtask

    // Issues one request, holds req until ready; lat = clock edges from request to ready.
    task automatic do_op(input bit port, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd);
        @(posedge sys_clk); #1;
        if (!port) begin bus.m0_req = 1'b1; bus.m0_op = op; bus.m0_addr = a; bus.m0_wdata = wd; end
        else       begin bus.m1_req = 1'b1; bus.m1_op = op; bus.m1_addr = a; bus.m1_wdata = wd; end
        lat = 99;
        rd  = '0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (port ? bus.m1_ready : bus.m0_ready) begin
                lat = n;
                rd  = port ? bus.m1_rdata : bus.m0_rdata;
                break;
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
    endtask

    task automatic test_reset;
        bus.m0_req = 0; bus.m0_op = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_op = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (bus.sfr_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_addr got=%0h exp=ffffffff", bus.sfr_addr); end
        checks++; if (bus.sfr_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b exp=0", bus.sfr_wr_en); end
        checks++; if ({bus.m0_ready, bus.m1_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%0b%0b exp=00", bus.m0_ready, bus.m1_ready); end
        checks++; if (bus.m0_rdata !== 32'h0) begin failures++; $display("FAIL rst_m0_rdata got=%0h exp=0", bus.m0_rdata); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL rst_owner got=%0b exp=0", owner); end
    endtask

    task automatic test_write_read;
        int lat, w0;
        logic [31:0] rd;
        poke(8'h10, 32'h0);
        w0 = wr_cnt;
        do_op(1'b0, 2'b01, 32'h10, 32'hA5A5_0001, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_prewrite_rdata got=%0h exp=0", rd); end
        checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL wr_pulses got=%0d exp=1", wr_cnt - w0); end
        checks++; if (last_wr_addr !== 32'h10) begin failures++; $display("FAIL wr_addr got=%0h exp=10", last_wr_addr); end
        checks++; if (last_wr_data !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_data got=%0h exp=a5a50001", last_wr_data); end
        w0 = wr_cnt;
        do_op(1'b0, 2'b00, 32'h10, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL rd_data got=%0h exp=a5a50001", rd); end
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL rd_no_write got=%0d exp=%0d", wr_cnt, w0); end
        repeat (3) @(negedge sys_clk);
        checks++; if (bus.m0_rdata !== 32'hA5A5_0001) begin failures++; $display("FAIL rd_hold got=%0h exp=a5a50001", bus.m0_rdata); end
    endtask

    task automatic test_set_clear;
        int lat;
        logic [31:0] rd;
        poke(8'h10, 32'h0000_00F0);
        do_op(1'b1, 2'b10, 32'h10, 32'h0000_000F, lat, rd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL set_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h0000_00F0) begin failures++; $display("FAIL set_rdata got=%0h exp=f0", rd); end
        checks++; if (last_wr_data !== 32'h0000_00FF) begin failures++; $display("FAIL set_wdata got=%0h exp=ff", last_wr_data); end
        do_op(1'b1, 2'b11, 32'h10, 32'h0000_00F0, lat, rd);
        checks++; if (rd !== 32'h0000_00FF) begin failures++; $display("FAIL clr_rdata got=%0h exp=ff", rd); end
        checks++; if (mem[8'h10] !== 32'h0000_000F) begin failures++; $display("FAIL clr_sfr got=%0h exp=f", mem[8'h10]); end
        checks++; if (bus.m0_rdata !== 32'hA5A5_0001) begin failures++; $display("FAIL m0_rdata_isolated got=%0h exp=a5a50001", bus.m0_rdata); end
    endtask

    task automatic test_reset_mid_rmw;
        int w0, r0, r1;
        poke(8'h30, 32'h0000_0100);
        w0 = wr_cnt; r0 = rdy0_cnt; r1 = rdy1_cnt;
        @(posedge sys_clk); #1;
        bus.m0_req = 1'b1; bus.m0_op = 2'b10; bus.m0_addr = 32'h30; bus.m0_wdata = 32'h1;
        @(posedge sys_clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmw_busy got=%0b exp=1", busy); end
        sys_rst = 1'b1;
        bus.m0_req = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmw_rst_idle got=%0b exp=0", busy); end
        repeat (4) @(negedge sys_clk);
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL rmw_rst_no_write got=%0d exp=%0d", wr_cnt, w0); end
        checks++; if (rdy0_cnt + rdy1_cnt !== r0 + r1) begin failures++; $display("FAIL rmw_rst_no_ready got=%0d exp=%0d", rdy0_cnt + rdy1_cnt, r0 + r1); end
        checks++; if (mem[8'h30] !== 32'h0000_0100) begin failures++; $display("FAIL rmw_rst_sfr got=%0h exp=100", mem[8'h30]); end
    endtask

    task automatic test_round_robin;
        int rp[8], rc[8];
        logic [31:0] rdv[8];
        int n = 0;
        int exp_p[4] = '{0, 1, 0, 1};
        int exp_c[4] = '{2, 5, 8, 11};
        logic [31:0] exp_d[4] = '{32'h11, 32'h22, 32'h11, 32'h22};
        poke(8'h20, 32'h11);
        poke(8'h24, 32'h22);
        @(posedge sys_clk); #1;
        bus.m0_req = 1'b1; bus.m0_op = 2'b00; bus.m0_addr = 32'h20;
        bus.m1_req = 1'b1; bus.m1_op = 2'b00; bus.m1_addr = 32'h24;
        for (int c = 1; c <= 12; c++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if ((bus.m0_ready || bus.m1_ready) && n < 8) begin
                rp[n]  = bus.m1_ready ? 1 : 0;
                rc[n]  = c;
                rdv[n] = bus.m1_ready ? bus.m1_rdata : bus.m0_rdata;
                n++;
            end
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        checks++; if (n !== 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", n); end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                checks++; if (rp[i] !== exp_p[i]) begin failures++; $display("FAIL rr_port[%0d] got=%0d exp=%0d", i, rp[i], exp_p[i]); end
                checks++; if (rc[i] !== exp_c[i]) begin failures++; $display("FAIL rr_cycle[%0d] got=%0d exp=%0d", i, rc[i], exp_c[i]); end
                checks++; if (rdv[i] !== exp_d[i]) begin failures++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, rdv[i], exp_d[i]); end
            end
        end
        repeat (2) @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_req_drop;
        int w0, r0, lat;
        logic [31:0] rd;
        poke(8'h40, 32'h0000_BEEF);
        w0 = wr_cnt; r0 = rdy0_cnt; lat = 99; rd = '0;
        @(posedge sys_clk); #1;
        bus.m0_req = 1'b1; bus.m0_op = 2'b00; bus.m0_addr = 32'h40; bus.m0_wdata = 32'h0;
        @(posedge sys_clk); #1;
        bus.m0_req = 1'b0; bus.m0_op = 2'b01; bus.m0_wdata = 32'hDEAD;
        for (int n = 1; n <= 8; n++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (bus.m0_ready) begin lat = n + 1; rd = bus.m0_rdata; break; end
        end
        repeat (4) @(negedge sys_clk);
        checks++; if (lat !== 2) begin failures++; $display("FAIL drop_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0000_BEEF) begin failures++; $display("FAIL drop_rdata got=%0h exp=beef", rd); end
        checks++; if (rdy0_cnt - r0 !== 1) begin failures++; $display("FAIL drop_ready_pulses got=%0d exp=1", rdy0_cnt - r0); end
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL drop_no_write got=%0d exp=%0d", wr_cnt, w0); end
        checks++; if (mem[8'h40] !== 32'h0000_BEEF) begin failures++; $display("FAIL drop_sfr got=%0h exp=beef", mem[8'h40]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_set_clear();
        test_reset_mid_rmw();
        test_round_robin();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
